branch_resolve_unit: RTL and testbench

- Execute-stage consumer of the ALU condition flags (Z, N, V, C) produced by a subtract (ALUControl = 3'b001).
- Evaluates the RISC-V branch condition from funct3 and resolves jumps.
- On a taken branch or jump, issues a registered PC redirect to fetch with a valid/ready handshake, then flushes the wrong-path IF/ID and ID/EX registers.
- Fetch uses predict-not-taken, so every taken branch or jump redirects.

---
 rtl/bru_pkg.sv | 20 ++
 rtl/branch_cond_eval.sv | 33 +++
 rtl/branch_resolve_unit.sv | 166 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: funct3 encodings, FSM states
// and the flush counter width.
package bru_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } bru_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational RISC-V branch condition from funct3 and subtract flags (A-B).
// C is the no-borrow flag, so it is set when A >= B unsigned.
module branch_cond_eval
  import bru_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       z_i,
  input  logic       n_i,
  input  logic       v_i,
  input  logic       c_i,
  output logic       cond_o,
  output logic       illegal_o
);

  // funct3 decode into taken condition; 010/011 are reserved
  always_comb begin
    cond_o    = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_o = z_i;
      F3_BNE:  cond_o = ~z_i;
      F3_BLT:  cond_o = n_i ^ v_i;
      F3_BGE:  cond_o = ~(n_i ^ v_i);
      F3_BLTU: cond_o = ~c_i;
      F3_BGEU: cond_o = c_i;
      default: begin
        cond_o    = 1'b0;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution with a registered PC redirect handshake
// and post-redirect flush. Define BRU_PERF_CNT_EN to add performance counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  logic            ex_branch_i,
  input  logic            ex_jump_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic            ex_z_i,
  input  logic            ex_n_i,
  input  logic            ex_v_i,
  input  logic            ex_c_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            fetch_ready_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_ifid_o,
  output logic            flush_idex_o,
  output logic            stall_o,
  output logic            illegal_o
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches_o,
  output logic [31:0]     perf_taken_o,
  output logic [15:0]     perf_illegal_o
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);
  localparam logic [FLUSH_CNT_W-1:0] CNT_ONE    = FLUSH_CNT_W'(1);
  localparam logic [FLUSH_CNT_W-1:0] CNT_ZERO   = FLUSH_CNT_W'(0);

  bru_state_e             state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic                   illegal_q, illegal_d;
  logic                   cond_s, rsvd_s, taken_s, idle_s;

  branch_cond_eval u_cond (
    .funct3_i  (ex_funct3_i),
    .z_i       (ex_z_i),
    .n_i       (ex_n_i),
    .v_i       (ex_v_i),
    .c_i       (ex_c_i),
    .cond_o    (cond_s),
    .illegal_o (rsvd_s)
  );

  assign idle_s    = (state_q == IDLE);
  assign taken_s   = ex_valid_i & (ex_jump_i | (ex_branch_i & cond_s));
  // Anything arriving while busy is wrong-path and must not raise illegal_o
  assign illegal_d = idle_s & ex_valid_i & ex_branch_i & ~ex_jump_i & rsvd_s;

  // State, flush counter, redirect target and illegal pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      pc_q      <= {XLEN{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; the target is captured only on the IDLE->REQ transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (taken_s) begin
          state_d = REQ;
          pc_d    = ex_target_i;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (fetch_ready_i) begin
          if (FLUSH_CYCLES > 0) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = REQ;
        end
      end
      FLUSH: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = FLUSH;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the state register
  always_comb begin
    redirect_valid_o = 1'b0;
    stall_o          = 1'b0;
    flush_ifid_o     = 1'b0;
    flush_idex_o     = 1'b0;
    case (state_q)
      REQ: begin
        redirect_valid_o = 1'b1;
        stall_o          = 1'b1;
        flush_ifid_o     = 1'b1;
        flush_idex_o     = 1'b1;
      end
      FLUSH: begin
        flush_ifid_o = 1'b1;
        flush_idex_o = 1'b1;
      end
      default: begin
        redirect_valid_o = 1'b0;
        stall_o          = 1'b0;
      end
    endcase
  end

  assign redirect_pc_o = pc_q;
  assign illegal_o     = illegal_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_tk_q;
  logic [15:0] perf_il_q;

  // Event counters, frozen while a redirect or flush is in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_br_q <= 32'd0;
      perf_tk_q <= 32'd0;
      perf_il_q <= 16'd0;
    end else if (idle_s) begin
      if (ex_valid_i & ex_branch_i) perf_br_q <= perf_br_q + 32'd1;
      if (taken_s)                  perf_tk_q <= perf_tk_q + 32'd1;
      if (illegal_d)                perf_il_q <= perf_il_q + 16'd1;
    end
  end

  assign perf_branches_o = perf_br_q;
  assign perf_taken_o    = perf_tk_q;
  assign perf_illegal_o  = perf_il_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference model derived from
// operand comparisons queues expectations; a negedge monitor checks them.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int FC   = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ex_valid_i = 1'b0, ex_branch_i = 1'b0, ex_jump_i = 1'b0;
  logic [2:0]      ex_funct3_i = 3'd0;
  logic            ex_z_i = 1'b0, ex_n_i = 1'b0, ex_v_i = 1'b0, ex_c_i = 1'b0;
  logic [XLEN-1:0] ex_target_i = '0;
  logic            fetch_ready_i = 1'b0;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            flush_ifid_o, flush_idex_o, stall_o, illegal_o;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]     perf_branches_o, perf_taken_o;
  logic [15:0]     perf_illegal_o;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid_i       (ex_valid_i),
    .ex_branch_i      (ex_branch_i),
    .ex_jump_i        (ex_jump_i),
    .ex_funct3_i      (ex_funct3_i),
    .ex_z_i           (ex_z_i),
    .ex_n_i           (ex_n_i),
    .ex_v_i           (ex_v_i),
    .ex_c_i           (ex_c_i),
    .ex_target_i      (ex_target_i),
    .fetch_ready_i    (fetch_ready_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .flush_ifid_o     (flush_ifid_o),
    .flush_idex_o     (flush_idex_o),
    .stall_o          (stall_o),
    .illegal_o        (illegal_o)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches_o  (perf_branches_o),
    .perf_taken_o     (perf_taken_o),
    .perf_illegal_o   (perf_illegal_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rv;
    logic st;
    logic fl;
    logic ill;
  } exp_t;

  exp_t            cyc_q[$];
  logic [XLEN-1:0] pc_q[$];
  int n_pass = 0;
  int n_total = 0;

  // Reference model state: pending redirect, flush cycles left, illegal next cycle
  bit m_req = 1'b0;
  int m_flush = 0;
  bit m_ill_next = 1'b0;
  int m_br = 0, m_tk = 0, m_il = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Branch outcome decided straight from the operands
  function automatic bit rule(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              output bit rsvd);
    rsvd = 1'b0;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: begin rsvd = 1'b1; return 1'b0; end
    endcase
  endfunction

  // Called #1 after a rising edge: record this cycle's expected outputs,
  // drive the inputs, and advance the model to the next edge.
  task automatic issue(input bit v, input bit br, input bit jmp, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] tgt, input bit rdy);
    exp_t e;
    logic [32:0] d;
    bit cond, rsvd;
    e.rv = m_req; e.st = m_req; e.fl = m_req || (m_flush > 0); e.ill = m_ill_next;
    cyc_q.push_back(e);
    d = {1'b0, a} - {1'b0, b};
    ex_valid_i = v; ex_branch_i = br; ex_jump_i = jmp; ex_funct3_i = f3;
    ex_z_i = (d[31:0] == 32'd0);
    ex_n_i = d[31];
    ex_v_i = (a[31] != b[31]) && (d[31] != a[31]);
    ex_c_i = ~d[32];
    ex_target_i = tgt;
    fetch_ready_i = rdy;
    cond = rule(f3, a, b, rsvd);
    m_ill_next = 1'b0;
    if (m_req) begin
      if (rdy) begin m_req = 1'b0; m_flush = FC; end
    end else if (m_flush > 0) begin
      m_flush--;
    end else begin
      if (v && br) m_br++;
      if (v && (jmp || (br && cond))) begin
        m_req = 1'b1; m_tk++;
        pc_q.push_back(tgt);
      end
      if (v && br && !jmp && rsvd) begin m_ill_next = 1'b1; m_il++; end
    end
  endtask

  task automatic step(input bit v, input bit br, input bit jmp, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] tgt, input bit rdy);
    @(posedge clk); #1;
    issue(v, br, jmp, f3, a, b, tgt, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, 3'($urandom), $urandom, $urandom, $urandom, rdy);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_redirect_valid"}, redirect_valid_o, 1'b0);
    chk({tag, "_redirect_pc"}, redirect_pc_o, 32'd0);
    chk({tag, "_flush_ifid"}, flush_ifid_o, 1'b0);
    chk({tag, "_flush_idex"}, flush_idex_o, 1'b0);
    chk({tag, "_stall"}, stall_o, 1'b0);
    chk({tag, "_illegal"}, illegal_o, 1'b0);
  endtask

  task automatic reset_mid();
    @(posedge clk); #3;
    rst = 1'b0; ex_valid_i = 1'b0;
    #1;
    check_all_zero("async_reset");
    cyc_q.delete(); pc_q.delete();
    m_req = 1'b0; m_flush = 0; m_ill_next = 1'b0;
    m_br = 0; m_tk = 0; m_il = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    issue(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1);
  endtask

  // Monitor: per-cycle control outputs, and redirect target popped on handshake
  always @(negedge clk) begin
    if (rst) begin
      if (cyc_q.size() == 0) begin
        chk("expectation_available", 64'd0, 64'd1);
      end else begin
        exp_t e;
        e = cyc_q.pop_front();
        chk("redirect_valid", redirect_valid_o, e.rv);
        chk("stall", stall_o, e.st);
        chk("flush_ifid", flush_ifid_o, e.fl);
        chk("flush_idex", flush_idex_o, e.fl);
        chk("illegal", illegal_o, e.ill);
      end
      if (redirect_valid_o) begin
        if (pc_q.size() == 0) begin
          chk("redirect_expected", 64'd0, 64'd1);
        end else begin
          chk("redirect_pc", redirect_pc_o, pc_q[0]);
          if (fetch_ready_i) void'(pc_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    issue(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1);

    // BEQ taken, immediate handshake, single flush cycle
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h55, 32'h55, 32'h0000_0100, 1'b1);
    repeat (3) idle(1'b1);

    // BLT -5 < 3 taken; BLTU with same operands not taken
    step(1'b1, 1'b1, 1'b0, 3'd4, -32'sd5, 32'd3, 32'h0000_0200, 1'b1);
    repeat (3) idle(1'b1);
    step(1'b1, 1'b1, 1'b0, 3'd6, -32'sd5, 32'd3, 32'h0000_0300, 1'b1);
    repeat (2) idle(1'b1);

    // BGEU taken with fetch stalled 4 cycles and a wrong-path jump injected
    step(1'b1, 1'b1, 1'b0, 3'd7, 32'd10, 32'd3, 32'h0000_0400, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 32'h0000_0BAD, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    repeat (2) idle(1'b1);

    // Reserved funct3
    step(1'b1, 1'b1, 1'b0, 3'd2, 32'd1, 32'd1, 32'h0000_0500, 1'b1);
    repeat (2) idle(1'b1);

    // Reset during REQ, then JAL to 0x2000
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 32'h0000_1234, 1'b0);
    idle(1'b0);
    #1;
    chk("pre_reset_in_req", redirect_valid_o, 1'b1);
    reset_mid();
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 32'h0000_2000, 1'b1);
    repeat (3) idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 16)) - 32'd8 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 16)) - 32'd8 : $urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
           3'($urandom), a, b, $urandom, $urandom_range(0, 2) != 0);
    end
    repeat (5) idle(1'b1);
    @(negedge clk); #1;
    chk("redirect_queue_drained", 64'(pc_q.size()), 64'd0);
`ifdef BRU_PERF_CNT_EN
    chk("perf_branches", perf_branches_o, 32'(m_br));
    chk("perf_taken", perf_taken_o, 32'(m_tk));
    chk("perf_illegal", perf_illegal_o, 16'(m_il));
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
